// File: rtl/svm_batch_driver.sv
// Batch initiator for the SVM classifier: replays a host-loaded sample buffer and tallies returned labels.
// Optional label log enabled by defining SVM_DRV_LOG_EN (adds rd_addr/rd_label).
module svm_batch_driver #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 32,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_expect,
    input  logic              start,
    input  logic [ADDR_W:0]   batch_len,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [ADDR_W:0]   pos_count,
    output logic [ADDR_W:0]   mismatch_count,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    input  logic              sample_ready,
    input  logic              label_in,
    input  logic              label_valid_in,
    output logic              label_ready,
`ifdef SVM_DRV_LOG_EN
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_label,
`endif
    output logic [1:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // sample/sample_valid hold steady until that edge, and ready never depends on valid.

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEND   = 2'd1,
        S_WAIT   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [DATA_W-1:0]   r_buf [DEPTH];
    logic                r_exp [DEPTH];
    logic [ADDR_W-1:0]   r_idx;
    logic [ADDR_W:0]     r_len;
    logic [ADDR_W:0]     r_pos;
    logic [ADDR_W:0]     r_mis;
    logic                r_timeout;
    logic [CNT_W-1:0]    r_wait_cnt;

    logic                w_start_ok;
    logic                w_sample_acc;
    logic                w_label_acc;
    logic                w_last;
    logic                w_expired;

    always_comb begin
        w_start_ok   = start && (r_state == S_IDLE);
        w_sample_acc = (r_state == S_SEND) && sample_ready;
        w_label_acc  = (r_state == S_WAIT) && label_valid_in;
        w_last       = (({1'b0, r_idx} + (ADDR_W + 1)'(1)) >= r_len);
        // A label arriving on the final allowed cycle takes priority over the abort.
        w_expired    = (r_state == S_WAIT) && !label_valid_in &&
                       (r_wait_cnt == CNT_W'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        sample_valid = 1'b0;
        label_ready  = 1'b0;
        sample       = '0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = (batch_len == '0) ? S_FINISH : S_SEND;
            end
            S_SEND: begin
                busy         = 1'b1;
                sample_valid = 1'b1;
                sample       = r_buf[r_idx];
                if (sample_ready) w_next = S_WAIT;
            end
            S_WAIT: begin
                busy        = 1'b1;
                label_ready = 1'b1;
                if (label_valid_in) w_next = w_last ? S_FINISH : S_SEND;
                else if (w_expired) w_next = S_FINISH;
            end
            S_FINISH: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Host writes are blocked only while a batch is in flight.
    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            r_buf[wr_addr] <= wr_data;
            r_exp[wr_addr] <= wr_expect;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx      <= '0;
            r_len      <= '0;
            r_pos      <= '0;
            r_mis      <= '0;
            r_timeout  <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            if (w_start_ok) begin
                r_len     <= batch_len;
                r_idx     <= '0;
                r_pos     <= '0;
                r_mis     <= '0;
                r_timeout <= 1'b0;
            end
            if (w_sample_acc) begin
                r_wait_cnt <= '0;
            end else if ((r_state == S_WAIT) && !label_valid_in) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
            if (w_label_acc) begin
                r_pos <= r_pos + (ADDR_W + 1)'(label_in);
                r_mis <= r_mis + (ADDR_W + 1)'(label_in != r_exp[r_idx]);
                if (!w_last) r_idx <= r_idx + ADDR_W'(1);
            end
            if (w_expired) r_timeout <= 1'b1;
        end
    end

`ifdef SVM_DRV_LOG_EN
    logic [DEPTH-1:0] r_log;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_log <= '0;
        end else if (w_start_ok) begin
            r_log <= '0;
        end else if (w_label_acc) begin
            r_log[r_idx] <= label_in;
        end
    end

    assign rd_label = r_log[rd_addr];
`endif

    assign timeout        = r_timeout;
    assign pos_count      = r_pos;
    assign mismatch_count = r_mis;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_svm_batch_driver.sv
// Self-checking bench for svm_batch_driver: sample scoreboard plus per-scenario checks.
module tb_svm_batch_driver;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              wr_en, wr_expect, start, sample_ready, label_in, label_valid_in;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W:0]   batch_len;

    logic              busy, done, timeout, sample_valid, label_ready;
    logic [ADDR_W:0]   pos_count, mismatch_count;
    logic [DATA_W-1:0] sample;
    logic [1:0]        dbg_state;

    logic              b_busy, b_done, b_timeout, b_sample_valid, b_label_ready;
    logic [ADDR_W:0]   b_pos_count, b_mismatch_count;
    logic [DATA_W-1:0] b_sample;
    logic [1:0]        b_dbg_state;
`ifdef SVM_DRV_LOG_EN
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              rd_label, b_rd_label;
`endif

    svm_batch_driver #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(64)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_expect(wr_expect), .start(start), .batch_len(batch_len), .busy(busy),
        .done(done), .timeout(timeout), .pos_count(pos_count),
        .mismatch_count(mismatch_count), .sample(sample), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .label_in(label_in), .label_valid_in(label_valid_in),
        .label_ready(label_ready),
`ifdef SVM_DRV_LOG_EN
        .rd_addr(rd_addr), .rd_label(rd_label),
`endif
        .dbg_state(dbg_state)
    );

    svm_batch_driver #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(16)) u_dut16 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_expect(wr_expect), .start(start), .batch_len(batch_len), .busy(b_busy),
        .done(b_done), .timeout(b_timeout), .pos_count(b_pos_count),
        .mismatch_count(b_mismatch_count), .sample(b_sample), .sample_valid(b_sample_valid),
        .sample_ready(sample_ready), .label_in(label_in), .label_valid_in(label_valid_in),
        .label_ready(b_label_ready),
`ifdef SVM_DRV_LOG_EN
        .rd_addr(rd_addr), .rd_label(b_rd_label),
`endif
        .dbg_state(b_dbg_state)
    );

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] m_data [DEPTH];
    logic              m_exp  [DEPTH];
    int exp_pos, exp_mis;

    task automatic apply_reset();
        rst = 1'b1;
        wr_en = 0; wr_addr = '0; wr_data = '0; wr_expect = 0; start = 0; batch_len = '0;
        sample_ready = 0; label_in = 0; label_valid_in = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_q.delete();
    endtask

    task automatic load(input int a, input logic [DATA_W-1:0] d, input logic e);
        wr_en = 1; wr_addr = ADDR_W'(a); wr_data = d; wr_expect = e;
        m_data[a] = d; m_exp[a] = e;
        @(negedge clk);
        wr_en = 0;
    endtask

    task automatic begin_batch(input int len);
        start = 1; batch_len = (ADDR_W + 1)'(len);
        exp_pos = 0; exp_mis = 0;
        for (int i = 0; i < len; i++) exp_q.push_back(m_data[i]);
        @(negedge clk);
        start = 0;
    endtask

    // Classifier model for one sample: accept it, wait dly cycles, return lab.
    task automatic serve(input int i, input logic lab, input int dly);
        int n;
        logic [DATA_W-1:0] e;
        n = 0;
        while (!sample_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sample_valid !== 1'b1) begin
            errors++;
            $display("FAIL serve_valid[%0d]: sample_valid=%b required 1", i, sample_valid);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL serve_q[%0d]: expected queue empty, sample=%h", i, sample);
        end else begin
            e = exp_q.pop_front();
            if (sample !== e) begin
                errors++;
                $display("FAIL serve_sample[%0d]: got %h required %h", i, sample, e);
            end
        end
        sample_ready = 1;
        @(negedge clk);
        sample_ready = 0;
        checks++;
        if (label_ready !== 1'b1 || sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL serve_wait[%0d]: label_ready=%b sample_valid=%b required 1/0",
                     i, label_ready, sample_valid);
        end
        repeat (dly) @(negedge clk);
        label_valid_in = 1; label_in = lab;
        exp_pos += int'(lab);
        exp_mis += int'(lab != m_exp[i]);
        @(negedge clk);
        label_valid_in = 0; label_in = 0;
    endtask

    task automatic finish_check(input string nm);
        int n;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done: done=%b required 1", nm, done);
        end
        checks++;
        if (pos_count !== (ADDR_W + 1)'(exp_pos) || mismatch_count !== (ADDR_W + 1)'(exp_mis)) begin
            errors++;
            $display("FAIL %s_counts: pos=%0d mis=%0d required %0d %0d",
                     nm, pos_count, mismatch_count, exp_pos, exp_mis);
        end
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL %s_timeout: timeout=%b required 0", nm, timeout);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_pulse: done=%b busy=%b required 0/0", nm, done, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wr_en = 0; wr_addr = '0; wr_data = '0; wr_expect = 0; start = 0; batch_len = '0;
        sample_ready = 0; label_in = 0; label_valid_in = 0;
        #1;
        checks++;
        if ({busy, done, timeout, sample_valid, label_ready} !== 5'b0 ||
            pos_count !== '0 || mismatch_count !== '0 || sample !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b to=%b sv=%b lr=%b pos=%0d mis=%0d sample=%h required all 0",
                     busy, done, timeout, sample_valid, label_ready, pos_count, mismatch_count, sample);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (dbg_state !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: state=%0d busy=%b required 0 0", dbg_state, busy);
        end
    endtask

    task automatic test_basic();
        logic [3:0] ex, lab;
        ex = 4'b1101; lab = 4'b1001;
        apply_reset();
        for (int i = 0; i < 4; i++) load(i, $urandom, ex[i]);
        begin_batch(4);
        for (int i = 0; i < 4; i++) serve(i, lab[i], 32);
        checks++;
        if (exp_pos != 2 || exp_mis != 1) begin
            errors++;
            $display("FAIL basic_model: model pos=%0d mis=%0d required 2 1", exp_pos, exp_mis);
        end
        finish_check("basic");
    endtask

    task automatic test_zero_len();
        begin_batch(0);
        checks++;
        if (done !== 1'b1 || sample_valid !== 1'b0 || pos_count !== '0 || mismatch_count !== '0) begin
            errors++;
            $display("FAIL zero_len: done=%b sv=%b pos=%0d mis=%0d required 1 0 0 0",
                     done, sample_valid, pos_count, mismatch_count);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_end: done=%b sv=%b required 0 0", done, sample_valid);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        load(0, $urandom, 1'b1);
        load(1, $urandom, 1'b0);
        begin_batch(2);
        for (int c = 0; c < 10; c++) begin
            if (c == 0) begin
                wr_en = 1; wr_addr = 1; wr_data = ~m_data[1]; wr_expect = 1;
            end else begin
                wr_en = 0;
            end
            checks++;
            if (sample_valid !== 1'b1 || sample !== m_data[0]) begin
                errors++;
                $display("FAIL stall[%0d]: sv=%b sample=%h required 1 %h", c, sample_valid, sample, m_data[0]);
            end
            @(negedge clk);
        end
        wr_en = 0;
        serve(0, 1'b1, 3);
        serve(1, 1'b1, 3);
        finish_check("stall");
    endtask

    task automatic test_timeout();
        int n;
        apply_reset();
        load(0, $urandom, 1'b1);
        begin_batch(1);
        sample_ready = 1;
        @(negedge clk);
        sample_ready = 0;
        n = 0;
        while (b_label_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL timeout_cycles: wait cycles=%0d required 16", n);
        end
        checks++;
        if (b_done !== 1'b1 || b_timeout !== 1'b1 || b_pos_count !== '0) begin
            errors++;
            $display("FAIL timeout_flag: done=%b timeout=%b pos=%0d required 1 1 0", b_done, b_timeout, b_pos_count);
        end
        @(negedge clk);
        checks++;
        if (b_done !== 1'b0 || b_timeout !== 1'b1 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_sticky: done=%b timeout=%b busy=%b required 0 1 0", b_done, b_timeout, b_busy);
        end
    endtask

    task automatic test_spurious();
        apply_reset();
        label_valid_in = 1; label_in = 1;
        repeat (3) @(negedge clk);
        checks++;
        if (pos_count !== '0 || mismatch_count !== '0) begin
            errors++;
            $display("FAIL spurious_idle: pos=%0d mis=%0d required 0 0", pos_count, mismatch_count);
        end
        load(0, $urandom, 1'b0);
        load(1, $urandom, 1'b1);
        begin_batch(2);
        start = 1; batch_len = '0;
        @(negedge clk);
        start = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || pos_count !== '0 || sample !== m_data[0]) begin
            errors++;
            $display("FAIL spurious_send: busy=%b done=%b pos=%0d sample=%h required 1 0 0 %h",
                     busy, done, pos_count, sample, m_data[0]);
        end
        label_valid_in = 0; label_in = 0;
        serve(0, 1'b1, 2);
        serve(1, 1'b1, 2);
        finish_check("spurious");
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] nv;
        apply_reset();
        for (int i = 0; i < 5; i++) load(i, $urandom, 1'($urandom_range(0, 1)));
        begin_batch(5);
        serve(0, 1'b1, 2);
        serve(1, 1'b1, 2);
        sample_ready = 1;
        @(negedge clk);
        sample_ready = 0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, timeout, sample_valid, label_ready} !== 5'b0 ||
            pos_count !== '0 || mismatch_count !== '0 || sample !== '0) begin
            errors++;
            $display("FAIL midreset: busy=%b done=%b to=%b sv=%b lr=%b pos=%0d mis=%0d sample=%h required all 0",
                     busy, done, timeout, sample_valid, label_ready, pos_count, mismatch_count, sample);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        nv = ~m_data[0];
        wr_en = 1; wr_addr = '0; wr_data = nv; wr_expect = ~m_exp[0];
        m_data[0] = nv; m_exp[0] = ~m_exp[0];
        begin_batch(5);
        wr_en = 0;
        for (int i = 0; i < 5; i++) serve(i, 1'($urandom_range(0, 1)), $urandom_range(0, 5));
        finish_check("restart");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_stall();
        test_timeout();
        test_spurious();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
